// File: rtl/fir_pkg.sv
// Shared widths, data types, sequencer states and output saturation for the FIR MAC sequencer.
// Types only; no state.
package fir_pkg;

  localparam int DEF_NTAPS  = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 33;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Drop the Q1.15 product scaling (floor toward -inf), then clamp to the sample range.
  function automatic sample_t sat16(input acc_t acc);
    acc_t shifted;
    acc_t sat_hi;
    acc_t sat_lo;
    shifted = acc >>> (DEF_DATA_W - 1);
    sat_hi  = acc_t'((1 << (DEF_DATA_W - 1)) - 1);
    sat_lo  = acc_t'(-(1 << (DEF_DATA_W - 1)));
    if (shifted > sat_hi) begin
      return sample_t'(sat_hi[DEF_DATA_W-1:0]);
    end else if (shifted < sat_lo) begin
      return sample_t'(sat_lo[DEF_DATA_W-1:0]);
    end else begin
      return sample_t'(shifted[DEF_DATA_W-1:0]);
    end
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample stream, coefficient write port, MAC initiator port and filtered output of the sequencer.
// master = sequencer side, slave = surrounding datapath (source, MAC, output stage).
interface fir_mac_sequencer_if
  import fir_pkg::*;
#(
  parameter int NTAPS  = DEF_NTAPS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) ();

  localparam int AW = $clog2(NTAPS);

  logic                     sample_valid_i;
  logic signed [DATA_W-1:0] sample_i;
  logic                     sample_ready_o;

  logic                     coef_we_i;
  logic [AW-1:0]            coef_addr_i;
  logic signed [DATA_W-1:0] coef_i;

  logic                     mac_clk_en_o;
  logic signed [DATA_W-1:0] mac_a_o;
  logic signed [DATA_W-1:0] mac_b_o;
  logic signed [ACC_W-1:0]  mac_prev_o;
  logic signed [ACC_W-1:0]  mac_result_i;

  logic                     out_valid_o;
  logic signed [DATA_W-1:0] out_sample_o;
  logic                     busy_o;

  modport master (
    input  sample_valid_i, sample_i, coef_we_i, coef_addr_i, coef_i, mac_result_i,
    output sample_ready_o, mac_clk_en_o, mac_a_o, mac_b_o, mac_prev_o,
           out_valid_o, out_sample_o, busy_o
  );

  modport slave (
    output sample_valid_i, sample_i, coef_we_i, coef_addr_i, coef_i, mac_result_i,
    input  sample_ready_o, mac_clk_en_o, mac_a_o, mac_b_o, mac_prev_o,
           out_valid_o, out_sample_o, busy_o
  );

endinterface

// File: rtl/fir_delay_line.sv
// Circular sample delay line; write advances the pointer, tap 0 reads the newest sample.
// Read is combinational; writes are never refused (caller gates them).
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int NTAPS  = DEF_NTAPS,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             wr_en,
  input  logic signed [DATA_W-1:0]         wr_dat,
  input  logic [$clog2(NTAPS)-1:0]         tap,
  output logic signed [DATA_W-1:0]         rd_dat
);

  localparam int AW = $clog2(NTAPS);

  logic [AW-1:0]            wp_q;
  logic [AW-1:0]            wp_nxt;
  logic signed [DATA_W-1:0] mem_q [NTAPS];

  assign wp_nxt = wp_q + AW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      wp_q          <= wp_nxt;
      mem_q[wp_nxt] <= wr_dat;
    end
  end

  // Pointer arithmetic wraps naturally because NTAPS is a power of two.
  assign rd_dat = mem_q[wp_q - tap];

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR tap sequencer driving an external 16x16 MAC, one tap per transaction, one output per sample.
// Latency NTAPS*(1+MAC_LAT)+1 from accept to out_valid_o; samples accepted only in IDLE.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS   = DEF_NTAPS,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MAC_LAT = 1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  fir_mac_sequencer_if.master bus
);

  localparam int AW  = $clog2(NTAPS);
  localparam int WCW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  seq_state_t               state_q, state_d;
  logic [AW-1:0]            tap_q, tap_d;
  logic [WCW-1:0]           wait_q, wait_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic signed [DATA_W-1:0] coef_q [NTAPS];

  logic                     accept;
  logic                     coef_wr;
  logic signed [DATA_W-1:0] tap_dat;

  logic                     ready_c;
  logic                     mac_en_c;
  logic signed [DATA_W-1:0] mac_a_c;
  logic signed [DATA_W-1:0] mac_b_c;
  logic signed [ACC_W-1:0]  mac_prev_c;
  logic                     out_valid_c;

  assign accept  = (state_q == IDLE) && bus.sample_valid_i;
  assign coef_wr = (state_q == IDLE) && bus.coef_we_i;

  fir_delay_line #(
    .NTAPS  (NTAPS),
    .DATA_W (DATA_W)
  ) u_delay_line (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wr_en  (accept),
    .wr_dat (bus.sample_i),
    .tap    (tap_q),
    .rd_dat (tap_dat)
  );

  // A write landing in the accept cycle is visible from tap 0 onwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else if (coef_wr) begin
      coef_q[bus.coef_addr_i] <= bus.coef_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tap_q   <= '0;
      wait_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      wait_q  <= wait_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    wait_d      = wait_q;
    acc_d       = acc_q;
    out_d       = out_q;
    ready_c     = 1'b0;
    mac_en_c    = 1'b0;
    mac_a_c     = '0;
    mac_b_c     = '0;
    mac_prev_c  = '0;
    out_valid_c = 1'b0;

    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.sample_valid_i) begin
          tap_d   = '0;
          state_d = ISSUE;
        end
      end

      ISSUE, WAIT: begin
        // Operands depend only on registered state, so they stay put for the whole tap.
        mac_en_c   = 1'b1;
        mac_a_c    = tap_dat;
        mac_b_c    = coef_q[tap_q];
        mac_prev_c = (tap_q == '0) ? '0 : acc_q;
        if (state_q == ISSUE) begin
          wait_d  = WCW'(MAC_LAT - 1);
          state_d = WAIT;
        end else if (wait_q == '0) begin
          acc_d = bus.mac_result_i;
          if (tap_q == AW'(NTAPS - 1)) begin
            out_d   = sat16(acc_t'(bus.mac_result_i));
            state_d = DONE;
          end else begin
            tap_d   = tap_q + AW'(1);
            state_d = ISSUE;
          end
        end else begin
          wait_d = wait_q - WCW'(1);
        end
      end

      DONE: begin
        out_valid_c = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.sample_ready_o = ready_c;
  assign bus.mac_clk_en_o   = mac_en_c;
  assign bus.mac_a_o        = mac_a_c;
  assign bus.mac_b_o        = mac_b_c;
  assign bus.mac_prev_o     = mac_prev_c;
  assign bus.out_valid_o    = out_valid_c;
  assign bus.out_sample_o   = out_q;
  assign bus.busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: MAC_LAT=1 instance for function, MAC_LAT=3 instance for protocol.
module tb_fir_mac_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fir_mac_sequencer_if m1 ();
  fir_mac_sequencer_if m3 ();

  fir_mac_sequencer #(.MAC_LAT(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(m1));
  fir_mac_sequencer #(.MAC_LAT(3)) dut3 (.clk_i(clk), .rst_i(rst), .bus(m3));

  // MAC responders: result = prev + a*b, registered MAC_LAT times on enabled edges.
  always @(posedge clk) begin
    if (m1.mac_clk_en_o) m1.mac_result_i <= m1.mac_prev_o + m1.mac_a_o * m1.mac_b_o;
  end

  logic signed [32:0] p3 [3];
  always @(posedge clk) begin
    if (m3.mac_clk_en_o) begin
      p3[0] <= m3.mac_prev_o + m3.mac_a_o * m3.mac_b_o;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end
  assign m3.mac_result_i = p3[2];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr1(input logic [3:0] addr, input logic [15:0] val);
    m1.coef_we_i = 1'b1; m1.coef_addr_i = addr; m1.coef_i = val;
    tick(1);
    m1.coef_we_i = 1'b0;
  endtask

  task automatic send1(input logic [15:0] val);
    m1.sample_valid_i = 1'b1; m1.sample_i = val;
    tick(1);
    m1.sample_valid_i = 1'b0;
  endtask

  task automatic wait_out1(output logic [15:0] y);
    int n = 0;
    while (m1.out_valid_o !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    check("out_valid_seen", {m1.out_valid_o}, 64'h1);
    y = m1.out_sample_o;
  endtask

  task automatic run1(input logic [15:0] val, output logic [15:0] y);
    send1(val);
    wait_out1(y);
    tick(1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] y;
    logic [15:0] exp_y;
    int          pulses;

    rst = 1'b1;
    m1.sample_valid_i = 1'b0; m1.sample_i = '0; m1.coef_we_i = 1'b0; m1.coef_addr_i = '0; m1.coef_i = '0;
    m3.sample_valid_i = 1'b0; m3.sample_i = '0; m3.coef_we_i = 1'b0; m3.coef_addr_i = '0; m3.coef_i = '0;
    tick(2);
    check("rst_ready", {m1.sample_ready_o}, 64'h1);
    check("rst_busy", {m1.busy_o}, 64'h0);
    check("rst_out_valid", {m1.out_valid_o}, 64'h0);
    check("rst_mac_en", {m1.mac_clk_en_o}, 64'h0);
    check("rst_out_sample", {m1.out_sample_o}, 64'h0);
    check("rst_ready_lat3", {m3.sample_ready_o}, 64'h1);
    rst = 1'b0;

    // Unity tap, exact output timing.
    wr1(4'd0, 16'h7FFF);
    send1(16'h4000);
    check("unity_busy", {m1.busy_o}, 64'h1);
    check("unity_not_ready", {m1.sample_ready_o}, 64'h0);
    check("unity_tap0_a", {m1.mac_a_o}, 64'h4000);
    check("unity_tap0_b", {m1.mac_b_o}, 64'h7FFF);
    check("unity_tap0_prev", {m1.mac_prev_o}, 64'h0);
    tick(31);
    check("unity_T32_no_valid", {m1.out_valid_o}, 64'h0);
    tick(1);
    check("unity_T33_valid", {m1.out_valid_o}, 64'h1);
    check("unity_out", {m1.out_sample_o}, 64'h3FFF);
    tick(1);
    check("unity_T34_no_valid", {m1.out_valid_o}, 64'h0);
    check("unity_T34_ready", {m1.sample_ready_o}, 64'h1);
    check("unity_out_hold", {m1.out_sample_o}, 64'h3FFF);

    // Reset during WAIT of tap 5.
    wr1(4'd5, 16'h1111);
    send1(16'h4000);
    tick(11);
    check("abort_in_wait", {m1.mac_clk_en_o}, 64'h1);
    check("abort_tap5_b", {m1.mac_b_o}, 64'h1111);
    check("abort_tap5_prev", {m1.mac_prev_o}, 64'h1FFFC000);
    pulse_reset();
    check("abort_busy", {m1.busy_o}, 64'h0);
    check("abort_ready", {m1.sample_ready_o}, 64'h1);
    check("abort_out_cleared", {m1.out_sample_o}, 64'h0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (m1.out_valid_o === 1'b1) pulses++;
      tick(1);
    end
    check("abort_no_pulse", 64'(pulses), 64'h0);
    send1(16'h2000);
    check("clr_coef0", {m1.mac_b_o}, 64'h0);
    check("clr_new_sample", {m1.mac_a_o}, 64'h2000);
    tick(2);
    check("clr_buf_tap1", {m1.mac_a_o}, 64'h0);
    tick(8);
    check("clr_coef5", {m1.mac_b_o}, 64'h0);
    tick(20);
    check("clr_buf_tap15", {m1.mac_a_o}, 64'h0);
    tick(2);
    check("clr_valid", {m1.out_valid_o}, 64'h1);
    check("clr_out", {m1.out_sample_o}, 64'h0);
    tick(1);

    // Impulse response through a ramp of coefficients, including pointer wrap.
    pulse_reset();
    for (int k = 0; k < 16; k++) wr1(4'(k), 16'(k * 256));
    for (int n = 0; n < 17; n++) begin
      run1((n == 0) ? 16'h7FFF : 16'h0000, y);
      exp_y = (n == 0 || n == 16) ? 16'h0000 : 16'(n * 256 - 1);
      check($sformatf("impulse_%0d", n), {y}, {48'h0, exp_y});
    end

    // Saturation corners.
    pulse_reset();
    wr1(4'd0, 16'h7FFF);
    wr1(4'd1, 16'h7FFF);
    run1(16'h7FFF, y);
    check("sat_first", {y}, 64'h7FFE);
    run1(16'h7FFF, y);
    check("sat_pos_two_taps", {y}, 64'h7FFF);
    pulse_reset();
    wr1(4'd0, 16'h8000);
    run1(16'h8000, y);
    check("sat_neg_times_neg", {y}, 64'h7FFF);
    run1(16'h7FFF, y);
    check("neg_times_pos", {y}, 64'h8001);

    // Sample and coefficient write offered while busy are both dropped.
    send1(16'h1000);
    tick(4);
    m1.sample_valid_i = 1'b1; m1.sample_i = 16'h7777;
    m1.coef_we_i = 1'b1; m1.coef_addr_i = 4'd0; m1.coef_i = 16'h1234;
    tick(1);
    m1.sample_valid_i = 1'b0; m1.coef_we_i = 1'b0;
    check("busy_still_busy", {m1.busy_o}, 64'h1);
    wait_out1(y);
    check("busy_out", {y}, 64'hF000);
    tick(1);
    send1(16'h0300);
    check("busy_coef_unchanged", {m1.mac_b_o}, 64'h8000);
    tick(2);
    check("busy_sample_dropped", {m1.mac_a_o}, 64'h1000);
    wait_out1(y);
    check("busy_next_out", {y}, 64'hFD00);
    tick(1);

    // Same-cycle coefficient write and accept in IDLE.
    m1.coef_we_i = 1'b1; m1.coef_addr_i = 4'd0; m1.coef_i = 16'h0100;
    m1.sample_valid_i = 1'b1; m1.sample_i = 16'h0200;
    tick(1);
    m1.coef_we_i = 1'b0; m1.sample_valid_i = 1'b0;
    check("samecyc_coef", {m1.mac_b_o}, 64'h0100);
    check("samecyc_sample", {m1.mac_a_o}, 64'h0200);
    wait_out1(y);
    check("samecyc_out", {y}, 64'h0004);
    tick(1);

    // MAC_LAT=3: operands stable for 4 cycles per tap.
    m3.coef_we_i = 1'b1; m3.coef_addr_i = 4'd0; m3.coef_i = 16'h7FFF;
    tick(1);
    m3.coef_addr_i = 4'd1; m3.coef_i = 16'h2000;
    tick(1);
    m3.coef_we_i = 1'b0;
    m3.sample_valid_i = 1'b1; m3.sample_i = 16'h4000;
    tick(1);
    m3.sample_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lat3_tap0_en_%0d", i), {m3.mac_clk_en_o}, 64'h1);
      check($sformatf("lat3_tap0_a_%0d", i), {m3.mac_a_o}, 64'h4000);
      check($sformatf("lat3_tap0_b_%0d", i), {m3.mac_b_o}, 64'h7FFF);
      check($sformatf("lat3_tap0_prev_%0d", i), {m3.mac_prev_o}, 64'h0);
      tick(1);
    end
    check("lat3_tap1_prev", {m3.mac_prev_o}, 64'h1FFFC000);
    check("lat3_tap1_b", {m3.mac_b_o}, 64'h2000);
    check("lat3_tap1_a", {m3.mac_a_o}, 64'h0);
    tick(59);
    check("lat3_T64_no_valid", {m3.out_valid_o}, 64'h0);
    tick(1);
    check("lat3_T65_valid", {m3.out_valid_o}, 64'h1);
    check("lat3_out", {m3.out_sample_o}, 64'h3FFF);
    tick(1);
    check("lat3_ready_again", {m3.sample_ready_o}, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
